// File: rtl/hough_accum.sv
// Hough (phi, r) vote accumulator: saturating bin counters in a synchronous RAM with a
// forwarded read-modify-write pipeline, plus a sequential threshold peak scanner.
module hough_accum #(
  parameter int N_PHI    = 180,
  parameter int N_R      = 1601,
  parameter int R_OFFSET = 800,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 19
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             vote_valid_i,
  output logic             vote_ready_o,
  input  logic [7:0]       vote_phi_i,
  input  logic [11:0]      vote_r_i,
  input  logic             start_clear_i,
  input  logic             start_scan_i,
  input  logic [CNT_W-1:0] threshold_i,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             peak_valid_o,
  output logic [7:0]       peak_phi_o,
  output logic [11:0]      peak_r_o,
  output logic [CNT_W-1:0] peak_cnt_o,
  output logic [15:0]      oor_cnt_o
);

  localparam int                DEPTH     = N_PHI * N_R;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [11:0]       R_LAST    = 12'(N_R - 1);
  localparam logic [11:0]       R_OFF12   = 12'(R_OFFSET);

  typedef enum logic [1:0] {StClear, StIdle, StDrain, StScan} state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic              to_scan_q, to_scan_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [7:0]        phi_q, phi_d;
  logic [11:0]       rbin_q, rbin_d;
  logic              tail_q, tail_d;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic              s2_fwd_q, s2_fwd_d;
  logic [CNT_W-1:0]  s2_fwd_data_q, s2_fwd_data_d;
  logic [15:0]       oor_q, oor_d;

  logic              p1_valid_q, p1_valid_d;
  logic              p1_last_q, p1_last_d;
  logic [7:0]        p1_phi_q, p1_phi_d;
  logic [11:0]       p1_rbin_q, p1_rbin_d;
  logic              done_pend_q, done_pend_d;
  logic              scan_done_q, scan_done_d;
  logic              peak_valid_q, peak_valid_d;
  logic [7:0]        peak_phi_q, peak_phi_d;
  logic [11:0]       peak_r_q, peak_r_d;
  logic [CNT_W-1:0]  peak_cnt_q, peak_cnt_d;

  logic [CNT_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]  ram_rdata_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]  ram_wdata;

  logic signed [31:0] r_bin;
  logic signed [31:0] vote_addr_full;
  logic [ADDR_W-1:0]  vote_addr;
  logic               vote_in_range;
  logic               vote_fire;
  logic               cmd_accept;
  logic               last_addr;
  logic               scan_issue;
  logic               clear_wr;
  logic [CNT_W-1:0]   s2_old, s2_new;
  logic               hit;

  assign r_bin          = $signed({{20{vote_r_i[11]}}, vote_r_i}) + R_OFFSET;
  assign vote_addr_full = $signed({24'd0, vote_phi_i}) * N_R + r_bin;
  assign vote_addr      = ADDR_W'(vote_addr_full);
  assign vote_in_range  = ($signed({24'd0, vote_phi_i}) < N_PHI) && (r_bin >= 0) && (r_bin < N_R);

  assign vote_fire  = vote_valid_i && (state_q == StIdle);
  assign cmd_accept = (state_q == StIdle) && (start_clear_i || start_scan_i);
  assign last_addr  = (addr_q == LAST_ADDR);
  assign scan_issue = (state_q == StScan) && !tail_q;
  assign clear_wr   = (state_q == StClear);

  // Back-to-back votes to one bin: RAM data is stale, so use the value forwarded from stage 2.
  assign s2_old = s2_fwd_q ? s2_fwd_data_q : ram_rdata_q;
  assign s2_new = (&s2_old) ? s2_old : s2_old + 1'b1;
  assign hit    = p1_valid_q && (ram_rdata_q >= thr_q);

  // Control FSM
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    to_scan_d = to_scan_q;
    thr_d     = thr_q;
    phi_d     = phi_q;
    rbin_d    = rbin_q;
    tail_d    = tail_q;
    unique case (state_q)
      StClear: begin
        addr_d = addr_q + 1'b1;
        if (last_addr) begin
          state_d = StIdle;
          addr_d  = '0;
        end
      end
      StIdle: begin
        if (cmd_accept) begin
          state_d   = StDrain;
          drain_d   = 1'b0;
          addr_d    = '0;
          to_scan_d = !start_clear_i;
          if (!start_clear_i) thr_d = threshold_i;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        addr_d  = '0;
        phi_d   = '0;
        rbin_d  = '0;
        tail_d  = 1'b0;
        if (drain_q) state_d = to_scan_q ? StScan : StClear;
      end
      StScan: begin
        if (!tail_q) begin
          addr_d = addr_q + 1'b1;
          if (rbin_q == R_LAST) begin
            rbin_d = '0;
            phi_d  = phi_q + 8'd1;
          end else begin
            rbin_d = rbin_q + 12'd1;
          end
          if (last_addr) tail_d = 1'b1;
        end
        if (scan_done_q) state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  // Vote pipeline, out-of-range counter and scan compare pipeline
  always_comb begin
    s1_valid_d    = vote_fire && vote_in_range;
    s1_addr_d     = (vote_fire && vote_in_range) ? vote_addr : s1_addr_q;
    s2_valid_d    = s1_valid_q;
    s2_addr_d     = s1_addr_q;
    s2_fwd_d      = s1_valid_q && s2_valid_q && (s1_addr_q == s2_addr_q);
    s2_fwd_data_d = s2_new;

    oor_d = oor_q;
    if (clear_wr) begin
      oor_d = '0;
    end else if (vote_fire && !vote_in_range && (oor_q != 16'hFFFF)) begin
      oor_d = oor_q + 16'd1;
    end

    p1_valid_d   = scan_issue;
    p1_last_d    = scan_issue && last_addr;
    p1_phi_d     = phi_q;
    p1_rbin_d    = rbin_q;
    done_pend_d  = p1_last_q;
    scan_done_d  = done_pend_q;
    peak_valid_d = hit;
    peak_phi_d   = peak_phi_q;
    peak_r_d     = peak_r_q;
    peak_cnt_d   = peak_cnt_q;
    if (hit) begin
      peak_phi_d = p1_phi_q;
      peak_r_d   = p1_rbin_q - R_OFF12;
      peak_cnt_d = ram_rdata_q;
    end
  end

  always_comb begin
    ram_we    = clear_wr || s2_valid_q;
    ram_waddr = clear_wr ? addr_q : s2_addr_q;
    ram_wdata = clear_wr ? '0 : s2_new;
    ram_raddr = (state_q == StScan) ? addr_q : s1_addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StClear;
      addr_q        <= '0;
      drain_q       <= 1'b0;
      to_scan_q     <= 1'b0;
      thr_q         <= '0;
      phi_q         <= '0;
      rbin_q        <= '0;
      tail_q        <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_addr_q     <= '0;
      s2_fwd_q      <= 1'b0;
      s2_fwd_data_q <= '0;
      oor_q         <= '0;
      p1_valid_q    <= 1'b0;
      p1_last_q     <= 1'b0;
      p1_phi_q      <= '0;
      p1_rbin_q     <= '0;
      done_pend_q   <= 1'b0;
      scan_done_q   <= 1'b0;
      peak_valid_q  <= 1'b0;
      peak_phi_q    <= '0;
      peak_r_q      <= '0;
      peak_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      drain_q       <= drain_d;
      to_scan_q     <= to_scan_d;
      thr_q         <= thr_d;
      phi_q         <= phi_d;
      rbin_q        <= rbin_d;
      tail_q        <= tail_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s2_valid_q    <= s2_valid_d;
      s2_addr_q     <= s2_addr_d;
      s2_fwd_q      <= s2_fwd_d;
      s2_fwd_data_q <= s2_fwd_data_d;
      oor_q         <= oor_d;
      p1_valid_q    <= p1_valid_d;
      p1_last_q     <= p1_last_d;
      p1_phi_q      <= p1_phi_d;
      p1_rbin_q     <= p1_rbin_d;
      done_pend_q   <= done_pend_d;
      scan_done_q   <= scan_done_d;
      peak_valid_q  <= peak_valid_d;
      peak_phi_q    <= peak_phi_d;
      peak_r_q      <= peak_r_d;
      peak_cnt_q    <= peak_cnt_d;
    end
  end

  assign vote_ready_o = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign scan_done_o  = scan_done_q;
  assign peak_valid_o = peak_valid_q;
  assign peak_phi_o   = peak_phi_q;
  assign peak_r_o     = peak_r_q;
  assign peak_cnt_o   = peak_cnt_q;
  assign oor_cnt_o    = oor_q;

endmodule

// File: doc/hough_accum.md
# hough_accum

Hough vote accumulator and peak scanner. It is the receiving end of the (phi, r) vote stream produced by the Hough pre-processing datapath. It increments a bin counter in an internal synchronous RAM for every accepted vote. On command, it scans the whole accumulator and emits every bin whose count meets a threshold, which feeds line reconstruction.

## Interface
Parameters:
- N_PHI, 180: number of phi bins, in degrees 0..N_PHI-1.
- N_R, 1601: number of r bins.
- R_OFFSET, 800: bin index = r + R_OFFSET.
- CNT_W, 8: bin counter width; counters saturate.
- ADDR_W, 19: RAM address width; must satisfy 2^ADDR_W ≥ N_PHI*N_R.

Ports (clock and reset first):
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-high.
- vote_valid, in, 1: a vote is offered this cycle.
- vote_ready, out, 1: a vote is accepted when vote_valid & vote_ready.
- vote_phi, in, 8: unsigned phi bin.
- vote_r, in, 12: signed two's-complement r.
- start_clear, in, 1: single-cycle pulse requesting an accumulator clear.
- start_scan, in, 1: single-cycle pulse requesting a peak scan.
- threshold, in, CNT_W: minimum count for a bin to be reported as a peak.
- busy, out, 1: high during DRAIN, CLEAR or SCAN.
- scan_done, out, 1: single-cycle pulse at the end of a scan.
- peak_valid, out, 1: single-cycle qualifier for the peak_* outputs.
- peak_phi, out, 8: phi bin of the reported peak.
- peak_r, out, 12: signed r of the reported peak (bin − R_OFFSET).
- peak_cnt, out, CNT_W: count of the reported peak.
- oor_cnt, out, 16: number of dropped out-of-range votes; saturates at 0xFFFF.

## Operation
- States are CLEAR, IDLE, DRAIN, SCAN.
- Reset:
  - Asynchronously enters CLEAR with the clear address at 0.
  - vote_ready, scan_done, peak_valid and all peak_* outputs are 0.
  - busy is 1; oor_cnt is 0.
- CLEAR:
  - Writes 0 to addresses 0..N_PHI*N_R−1, one address per cycle.
  - Clears oor_cnt.
  - Goes to IDLE after the last address.
- IDLE:
  - vote_ready = 1.
  - An accepted vote is in range when vote_phi < N_PHI and 0 ≤ vote_r + R_OFFSET < N_R.
  - An in-range vote enters the read-modify-write pipeline at address vote_phi*N_R + vote_r + R_OFFSET.
  - An out-of-range vote increments oor_cnt and does not touch the RAM.
- Command acceptance:
  - Commands are sampled only in IDLE; a command arriving in any other state is ignored.
  - start_clear has priority over start_scan when both arrive in the same cycle.
  - An accepted command drops vote_ready in the next cycle; a vote presented in the command cycle itself is still accepted.
  - The block then goes to DRAIN for 2 cycles, so in-flight writes retire, and then to CLEAR or SCAN.
- Read-modify-write pipeline:
  - Stage 1 issues the RAM read.
  - Stage 2 computes new = min(old + 1, 2^CNT_W − 1) and writes it back.
  - If the stage-2 write address equals the stage-1 address, stage 1 takes the forwarded new value instead of RAM data. This way back-to-back votes to the same bin each count once.
- SCAN:
  - Reads addresses 0..N_PHI*N_R−1 sequentially, one per cycle.
  - Reports a peak for every bin with count ≥ threshold; threshold is sampled when the scan is accepted.
  - peak_phi = addr / N_PHI-bin stride and peak_r = addr mod N_R − R_OFFSET. Use incremental phi/r counters; no divider.
  - Pulses scan_done after the last compare, then returns to IDLE.
  - Bin contents are unchanged by a scan.
- A reset asserted in any state aborts that state and restarts CLEAR; in-flight votes are lost.

## Timing
- A vote accepted at cycle t: RAM read at t+1, write-back at t+2. A bin read in any cycle ≥ t+3 reflects the vote.
- Sustained throughput is one vote per cycle, with no bubbles, including same-bin runs.
- CLEAR takes N_PHI*N_R cycles. vote_ready rises in the cycle after the last clear write.
- Scan, with address a issued at cycle s+a:
  - peak_valid for address a occurs at s+a+2.
  - scan_done occurs at s+N_PHI*N_R+2.
  - busy falls in the cycle after scan_done.
- Command latency: DRAIN takes 2 cycles, so the first clear or scan address is issued 3 cycles after the command is accepted.
- oor_cnt updates in the cycle after the vote is accepted.

## Test plan
All scenarios use N_PHI=4, N_R=8, R_OFFSET=4, CNT_W=4.
1. Reset, then wait → busy stays high for exactly 32 cycles and then vote_ready=1. A scan with threshold=1 emits no peak_valid and one scan_done.
2. Three back-to-back votes (phi=1, r=−2), then a scan with threshold=3 → exactly one peak: peak_phi=1, peak_r=−2, peak_cnt=3. The forwarding path is exercised.
3. 20 consecutive votes to (phi=3, r=3), then a scan with threshold=15 → one peak with peak_cnt=15 (saturation).
4. Votes at (phi=4, r=0), (phi=0, r=4) and (phi=0, r=−5) → oor_cnt=3 and a scan with threshold=1 reports no peaks. Then start_clear → oor_cnt=0.
5. start_clear and start_scan in the same IDLE cycle → a clear runs and scan_done never pulses. start_scan issued during CLEAR is ignored.
6. Votes at (0,−4) and (2,1), scan with threshold=1, and reset asserted at scan address 10 → peak_valid=0 and busy=1 immediately. After the 32-cycle clear, a rescan reports no peaks.
